pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_if.sv | 30 +++
 rtl/pc_seq.sv | 165 ++++++++++++++++
 tb/tb_pc_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// pc_seq_if: groups the sequencer's instruction/flag inputs and PC/stack status outputs.
//   master : drives enable, IR, CCR; observes pc_output, hold, sp, stack_err
//   slave  : the sequencer side (pc_seq)
// Parameters must match the pc_seq instance they connect to.
interface pc_seq_if #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned INSTR_W     = 24,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned FLAG_W      = 4
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

    logic               enable;     // advance qualifier
    logic [INSTR_W-1:0] IR;         // current instruction
    logic [FLAG_W-1:0]  CCR;        // condition flags: bit0 CY, bit2 Z, bit3 N
    logic [ADDR_W-1:0]  pc_output;  // registered program counter
    logic               hold;       // conditional branch being evaluated
    logic [SP_W-1:0]    sp;         // return-stack entry count
    logic               stack_err;  // sticky overflow/underflow

    modport master (
        output enable, IR, CCR,
        input  pc_output, hold, sp, stack_err
    );

    modport slave (
        input  enable, IR, CCR,
        output pc_output, hold, sp, stack_err
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with jumps, two-cycle conditional branches and a
// return-address stack for CALL/BSR/RET.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pc_seq_if.slave (enable, IR, CCR in; pc_output, hold, sp, stack_err out)
module pc_seq #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned INSTR_W     = 24,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned FLAG_W      = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    pc_seq_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = PTR_W + 1;
    localparam int unsigned OP_W  = INSTR_W - ADDR_W;

    localparam logic [OP_W-1:0] OpJmp  = OP_W'(12'h800);
    localparam logic [OP_W-1:0] OpJze  = OP_W'(12'h801);
    localparam logic [OP_W-1:0] OpJne  = OP_W'(12'h802);
    localparam logic [OP_W-1:0] OpJcy  = OP_W'(12'h803);
    localparam logic [OP_W-1:0] OpRet  = OP_W'(12'h804);
    localparam logic [OP_W-1:0] OpBsr  = OP_W'(12'h805);
    localparam logic [OP_W-1:0] OpCall = OP_W'(12'h806);

    typedef enum logic [1:0] {StStart, StRun, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0]   br_op_q, br_op_d;    // conditional opcode latched on HOLD entry
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;  // its target, so IR may change during HOLD
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              push;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_inc;
    logic [PTR_W-1:0]  top_idx;
    logic              stack_full;
    logic              stack_empty;
    logic              is_cond;
    logic              flag;

    assign op          = bus.IR[INSTR_W-1:ADDR_W];
    assign tgt         = bus.IR[ADDR_W-1:0];
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign top_idx     = sp_q[PTR_W-1:0] - PTR_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign is_cond     = (op == OpJze) || (op == OpJne) || (op == OpJcy);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.enable) begin
            case (state_q)
                StStart: state_d = StRun;
                StRun:   state_d = is_cond ? StHold : StRun;
                StHold:  state_d = StRun;
                default: state_d = StStart;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus.hold = (state_q == StHold);
    end

    // Flag selected by the latched conditional opcode
    always_comb begin
        case (br_op_q)
            OpJze:   flag = bus.CCR[2];
            OpJne:   flag = bus.CCR[3];
            default: flag = bus.CCR[0];
        endcase
    end

    // Datapath next state
    always_comb begin
        pc_d     = pc_q;
        br_op_d  = br_op_q;
        br_tgt_d = br_tgt_q;
        sp_d     = sp_q;
        err_d    = err_q;
        push     = 1'b0;
        if (bus.enable) begin
            case (state_q)
                StRun: begin
                    case (op)
                        OpJmp: pc_d = tgt;
                        OpJze, OpJne, OpJcy: begin
                            br_op_d  = op;
                            br_tgt_d = tgt;
                        end
                        OpCall, OpBsr: begin
                            if (stack_full) begin
                                // Overflow: skip the call entirely
                                pc_d  = pc_inc;
                                err_d = 1'b1;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SP_W'(1);
                                pc_d = (op == OpCall) ? tgt : pc_q + tgt;
                            end
                        end
                        OpRet: begin
                            if (stack_empty) begin
                                pc_d  = pc_inc;
                                err_d = 1'b1;
                            end else begin
                                pc_d = stack_q[top_idx];
                                sp_d = sp_q - SP_W'(1);
                            end
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
                StHold:  pc_d = flag ? br_tgt_q : pc_inc;
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            br_op_q  <= '0;
            br_tgt_q <= '0;
            sp_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            br_op_q  <= br_op_d;
            br_tgt_q <= br_tgt_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
        end
    end

    // Stack contents need no reset; sp alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[PTR_W-1:0]] <= pc_inc;
        end
    end

    assign bus.pc_output = pc_q;
    assign bus.sp        = sp_q;
    assign bus.stack_err = err_q;
endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pc_seq_if bus ();

    pc_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [11:0] pc;
        logic        hold;
        logic [2:0]  sp;
        logic        err;
    } obs_t;

    typedef struct {
        logic        en;
        logic [23:0] ir;
        logic [3:0]  ccr;
        logic        arst;  // pulse reset mid-cycle instead of clocking
        obs_t        exp;
    } row_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk(input logic en, input logic [23:0] ir, input logic [3:0] ccr,
                                input logic [11:0] pc, input logic h, input logic [2:0] s,
                                input logic e);
        row_t r;
        r.en   = en;
        r.ir   = ir;
        r.ccr  = ccr;
        r.arst = 1'b0;
        r.exp  = obs_t'{pc, h, s, e};
        return r;
    endfunction

    function automatic obs_t observe();
        return obs_t'{bus.pc_output, bus.hold, bus.sp, bus.stack_err};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h hold=%b sp=%0d err=%b", o.pc, o.hold, o.sp, o.err);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.enable = 1'b0;
        bus.IR     = '0;
        bus.CCR    = '0;
        rst_n      = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        obs_t got, want;
        rst_n      = 1'b0;
        bus.enable = 1'b1;
        bus.IR     = 24'h800abc;
        bus.CCR    = '0;
        exp_q.push_back(obs_t'{12'h000, 1'b0, 3'd0, 1'b0});
        #1;
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_state got %s want %s", fmt(got), fmt(want));
        end
        @(negedge clk);
        rst_n = 1'b1;
        // First enabled edge after reset is the START cycle: IR (a JMP) is ignored
        rows.push_back(mk(1, 24'h800abc, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h800abc, 0, 12'habc, 0, 0, 0));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL start_cycle[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_count();
        row_t rows[$];
        obs_t got, want;
        do_reset();
        rows.push_back(mk(1, 24'h000000, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h000000, 0, 12'h001, 0, 0, 0));
        rows.push_back(mk(1, 24'h000000, 0, 12'h002, 0, 0, 0));
        rows.push_back(mk(1, 24'h000000, 0, 12'h003, 0, 0, 0));
        rows.push_back(mk(0, 24'h000000, 0, 12'h003, 0, 0, 0));
        rows.push_back(mk(1, 24'h123456, 0, 12'h004, 0, 0, 0));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL count[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_cond_branch();
        row_t rows[$];
        obs_t got, want;
        do_reset();
        rows.push_back(mk(1, 24'h000000, 4'h0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h800005, 4'h0, 12'h005, 0, 0, 0));
        // JZE: CCR sampled in the HOLD cycle, not at entry; IR during HOLD ignored
        rows.push_back(mk(1, 24'h801123, 4'h0, 12'h005, 1, 0, 0));
        rows.push_back(mk(0, 24'h800777, 4'h0, 12'h005, 1, 0, 0));
        rows.push_back(mk(1, 24'h000000, 4'h4, 12'h123, 0, 0, 0));
        rows.push_back(mk(1, 24'h800005, 4'h0, 12'h005, 0, 0, 0));
        rows.push_back(mk(1, 24'h801123, 4'h0, 12'h005, 1, 0, 0));
        rows.push_back(mk(1, 24'h801123, 4'h0, 12'h006, 0, 0, 0));
        // JNE looks at N only
        rows.push_back(mk(1, 24'h802040, 4'h0, 12'h006, 1, 0, 0));
        rows.push_back(mk(1, 24'h000000, 4'h4, 12'h007, 0, 0, 0));
        rows.push_back(mk(1, 24'h802040, 4'h0, 12'h007, 1, 0, 0));
        rows.push_back(mk(1, 24'h000000, 4'h8, 12'h040, 0, 0, 0));
        // JCY looks at CY only
        rows.push_back(mk(1, 24'h803300, 4'h0, 12'h040, 1, 0, 0));
        rows.push_back(mk(1, 24'h000000, 4'he, 12'h041, 0, 0, 0));
        rows.push_back(mk(1, 24'h803300, 4'h0, 12'h041, 1, 0, 0));
        rows.push_back(mk(1, 24'h000000, 4'h1, 12'h300, 0, 0, 0));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cond_branch[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_call_ret();
        row_t rows[$];
        obs_t got, want;
        do_reset();
        rows.push_back(mk(1, 24'h000000, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h800010, 0, 12'h010, 0, 0, 0));
        rows.push_back(mk(1, 24'h806200, 0, 12'h200, 0, 1, 0));
        rows.push_back(mk(1, 24'h804000, 0, 12'h011, 0, 0, 0));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL call_ret[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_stack_limits();
        row_t rows[$];
        obs_t got, want;
        do_reset();
        rows.push_back(mk(1, 24'h000000, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h800010, 0, 12'h010, 0, 0, 0));
        rows.push_back(mk(1, 24'h806100, 0, 12'h100, 0, 1, 0));
        rows.push_back(mk(1, 24'h806200, 0, 12'h200, 0, 2, 0));
        rows.push_back(mk(1, 24'h806300, 0, 12'h300, 0, 3, 0));
        rows.push_back(mk(1, 24'h806400, 0, 12'h400, 0, 4, 0));
        rows.push_back(mk(1, 24'h806500, 0, 12'h401, 0, 4, 1));
        rows.push_back(mk(0, 24'h804000, 0, 12'h401, 0, 4, 1));
        rows.push_back(mk(1, 24'h804000, 0, 12'h301, 0, 3, 1));
        rows.push_back(mk(1, 24'h804000, 0, 12'h201, 0, 2, 1));
        rows.push_back(mk(1, 24'h804000, 0, 12'h101, 0, 1, 1));
        rows.push_back(mk(1, 24'h804000, 0, 12'h011, 0, 0, 1));
        rows.push_back(mk(1, 24'h804000, 0, 12'h012, 0, 0, 1));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stack_limits[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_bsr_wrap();
        row_t rows[$];
        obs_t got, want;
        do_reset();
        rows.push_back(mk(1, 24'h000000, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h800ffe, 0, 12'hffe, 0, 0, 0));
        rows.push_back(mk(1, 24'h805003, 0, 12'h001, 0, 1, 0));
        rows.push_back(mk(1, 24'h804000, 0, 12'hfff, 0, 0, 0));
        rows.push_back(mk(1, 24'h000000, 0, 12'h000, 0, 0, 0));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bsr_wrap[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_in_hold();
        row_t rows[$];
        row_t r;
        obs_t got, want;
        do_reset();
        rows.push_back(mk(1, 24'h000000, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h804000, 0, 12'h001, 0, 0, 1));
        rows.push_back(mk(1, 24'h806100, 0, 12'h100, 0, 1, 1));
        rows.push_back(mk(1, 24'h806200, 0, 12'h200, 0, 2, 1));
        rows.push_back(mk(1, 24'h801050, 0, 12'h200, 1, 2, 1));
        r      = mk(1, 24'h000000, 4'h4, 12'h000, 0, 0, 0);
        r.arst = 1'b1;
        rows.push_back(r);
        rows.push_back(mk(0, 24'h8000aa, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(0, 24'h8000aa, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(0, 24'h8000aa, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h8000aa, 0, 12'h000, 0, 0, 0));
        rows.push_back(mk(1, 24'h8000aa, 0, 12'h0aa, 0, 0, 0));
        foreach (rows[i]) begin
            bus.enable = rows[i].en;
            bus.IR     = rows[i].ir;
            bus.CCR    = rows[i].ccr;
            exp_q.push_back(rows[i].exp);
            if (rows[i].arst) begin
                #2;
                rst_n = 1'b0;
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_in_hold[%0d] got %s want %s", i, fmt(got), fmt(want));
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.IR     = '0;
        bus.CCR    = '0;
        test_reset();
        test_count();
        test_cond_branch();
        test_call_ret();
        test_stack_limits();
        test_bsr_wrap();
        test_reset_in_hold();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
